if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `id_stage`. It owns the PC and issues requests to a synchronous-read instruction memory with one-cycle latency. It produces the IF/ID pipeline register (`if_id_instruction`, `if_id_pc_next`). A one-entry skid buffer preserves an in-flight fetch while ID holds, and a redirect from branch/jump resolution kills in-flight work.

## Interface
- `RESET_PC`, default 32'd0: PC loaded on reset.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: load-use stall from `id_stage`.
- `stall_breakpoint` input 1: breakpoint match from `id_stage`.
- `continue_en` input 1: breakpoint release from `id_stage`.
- `pc_redirect` input 1: taken branch/jump; redirect fetch.
- `pc_redirect_target` input 32: new PC when `pc_redirect`=1.
- `imem_en` output 1: read request this cycle.
- `imem_addr` output 32: read address, equal to `pc`.
- `imem_rdata` input 32: instruction for the address requested in the previous cycle.
- `if_id_instruction` output 32: IF/ID instruction, 0 is a bubble (NOP).
- `if_id_pc_next` output 32: fetched PC + 4. Bubble value is 0.
- `fetch_count` output 32: count of instructions delivered into IF/ID.

## Operation
- Internal signal: `hold` = `stall` | (`stall_breakpoint` & ~`continue_en`).
- State registers:
  - `pc`
  - `req_valid`, `req_pc`: the in-flight request
  - `skid_valid`, `skid_instr`, `skid_pc`
  - the IF/ID outputs
  - `fetch_count`
- Combinational outputs: `imem_addr` = `pc`. `imem_en` = ~`rst` & (`pc_redirect` | ~`hold`).
- Per-edge update, priority rst > redirect > hold > advance.
- rst:
  - `pc`=`RESET_PC`
  - `req_valid`=0, `skid_valid`=0
  - `if_id_instruction`=0, `if_id_pc_next`=0
  - `fetch_count`=0
  - `skid_instr`/`skid_pc`/`req_pc` cleared to 0.
- redirect (`pc_redirect`=1, regardless of hold):
  - `pc`←`pc_redirect_target`
  - `req_valid`←0, `skid_valid`←0
  - IF/ID←bubble (0,0)
  - `fetch_count` unchanged.
  - `imem_rdata` of this cycle is discarded.
- hold (no redirect):
  - `pc`, IF/ID, `fetch_count` held. No new request is issued, so `req_valid`←0.
  - If `req_valid`=1: `skid_instr`←`imem_rdata`, `skid_pc`←`req_pc`, `skid_valid`←1.
  - If `req_valid`=0: skid unchanged.
- advance (no redirect, no hold):
  - IF/ID source priority: skid (if `skid_valid`) then `imem_rdata` (if `req_valid`) then bubble.
  - `if_id_pc_next` = source PC + 4, modulo 2^32.
  - `skid_valid`←0.
  - `req_pc`←`pc`, `req_valid`←1, `pc`←`pc`+4 (wraps 0xFFFFFFFC→0).
  - `fetch_count`+1 when a non-bubble source loads, wraps at 2^32.
- Invariant: `skid_valid` and `req_valid` are never both 1. The skid is filled only on a hold cycle, which clears `req_valid`, so depth 1 suffices. The bench asserts this.
- Instruction value 0 from memory is delivered and counted like any other instruction; bubble-ness is not inferred from the value.

## Timing
- Fetch latency: address issued at edge N (`imem_en`=1), data in IF/ID after edge N+1 when unheld. Steady-state throughput is 1 instruction/cycle.
- Hold entry: the instruction in flight at the hold cycle is kept in the skid. On release it reaches IF/ID on the first advance edge, and the next sequential fetch follows with no bubble and no duplicate.
- Multi-cycle hold: the skid persists. `imem_en`=0 for the whole hold.
- Redirect: the target is requested at the first edge after redirect. The first target instruction is in IF/ID 2 edges after the redirect edge, with exactly 1 bubble after the redirect edge bubble.
- Redirect coincident with hold: redirect wins and the skid is flushed.
- Breakpoint: once `continue_en`=1, hold drops in the same cycle (combinational).
- Reset mid-hold or mid-redirect: all state returns to reset values at that edge. First fetch of `RESET_PC` is issued in the first cycle with `rst`=0.

## Test plan
- Reset release, memory[i]=0x20080000+i, no hold. Required response:
  - `imem_addr` 0,4,8…
  - IF/ID (0x20080000, 4) one edge after the first request, then (0x20080001, 8)…
  - `fetch_count` increments each edge.
- Load-use stall for 1 cycle while addr 8 is in flight. Required response:
  - IF/ID holds (…,8) through the stall.
  - Next edge gives (mem[8], 12), then (mem[12], 16).
  - No repeat, no gap.
- 3-cycle hold: `stall_breakpoint`=1, `continue_en`=0, then `continue_en`=1. Required response:
  - IF/ID frozen 3 edges.
  - `imem_en`=0 during hold.
  - The skid entry is delivered first after release.
- `pc_redirect`=1, target 0x40, while streaming at 0x10. Required response:
  - IF/ID bubble (0,0) at the redirect edge, then one further bubble.
  - Then (mem[0x40], 0x44).
  - In-flight 0x10 data is never delivered.
- `pc_redirect` and `stall` asserted together with the skid full. Required response:
  - The skid is discarded.
  - `pc`=target.
  - Later IF/ID contents come only from the target stream.
- `rst` pulsed during a hold with the skid full. Required response:
  - All outputs return to 0.
  - `fetch_count`=0.
  - Fetch restarts at `RESET_PC`.
  - The PC wrap case (start 0xFFFFFFF8) gives `if_id_pc_next` 0xFFFFFFFC, then 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, one-deep skid buffer for ID holds, and redirect flush
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        stall_breakpoint,
  input  logic        continue_en,
  input  logic        pc_redirect,
  input  logic [31:0] pc_redirect_target,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_next,
  output logic [31:0] fetch_count
);
  logic [31:0] pc, req_pc, skid_instr, skid_pc, src_instr, src_pc_next;
  logic req_valid, skid_valid, hold, src_valid;
  always_comb begin
    hold = stall | (stall_breakpoint & ~continue_en);
    imem_en = ~rst & (pc_redirect | ~hold);
    imem_addr = pc;
    src_valid = skid_valid | req_valid;
    src_instr = skid_valid ? skid_instr : req_valid ? imem_rdata : 32'd0;
    src_pc_next = skid_valid ? skid_pc + 32'd4 : req_valid ? req_pc + 32'd4 : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      req_valid <= 1'b0;
      req_pc <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc <= '0;
      if_id_instruction <= '0;
      if_id_pc_next <= '0;
      fetch_count <= '0;
    end else if (pc_redirect) begin
      pc <= pc_redirect_target;
      req_valid <= 1'b0;
      skid_valid <= 1'b0;
      if_id_instruction <= '0;
      if_id_pc_next <= '0;
    end else if (hold) begin
      // no request issues while held, so the in-flight read parks in the skid
      req_valid <= 1'b0;
      if (req_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc <= req_pc;
      end
    end else begin
      if_id_instruction <= src_instr;
      if_id_pc_next <= src_pc_next;
      fetch_count <= fetch_count + {31'd0, src_valid};
      skid_valid <= 1'b0;
      req_pc <= pc;
      req_valid <= 1'b1;
      pc <= pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a fetch-queue reference model
module tb_if_stage;
  logic clk = 0, rst = 1, stall = 0, stall_breakpoint = 0, continue_en = 0, pc_redirect = 0;
  logic [31:0] pc_redirect_target = 0, imem_rdata = 0;
  logic imem_en;
  logic [31:0] imem_addr, if_id_instruction, if_id_pc_next, fetch_count;
  int checks = 0, errors = 0;
  logic [31:0] m_pc = 0, m_instr = 0, m_pcn = 0, m_cnt = 0, exp_addr, obs_addr;
  logic exp_en, obs_en;
  logic [31:0] q[$];

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .stall_breakpoint(stall_breakpoint),
    .continue_en(continue_en), .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instruction(if_id_instruction), .if_id_pc_next(if_id_pc_next), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'd0 : 32'h20080000 + (a >> 2);
  endfunction

  // synchronous-read memory; unrequested cycles return garbage so stale data is never trusted
  always @(posedge clk) imem_rdata <= imem_en ? memf(imem_addr) : $urandom;

  always @(negedge clk) begin
    checks++;
    if (dut.skid_valid === 1'b1 && dut.req_valid === 1'b1) begin
      errors++;
      $display("FAIL skid_req_exclusive skid_valid=1 req_valid=1 required not both");
    end
  end

  // model: q holds addresses requested but not yet delivered, regardless of where the RTL parks them
  task automatic cyc(input logic st, input logic sb, input logic ce, input logic rd,
                     input logic [31:0] tgt, input logic r);
    logic h;
    logic [31:0] a;
    @(negedge clk);
    rst = r; stall = st; stall_breakpoint = sb; continue_en = ce;
    pc_redirect = rd; pc_redirect_target = tgt;
    #1;
    h = st | (sb & ~ce);
    exp_en = ~r & (rd | ~h);
    exp_addr = m_pc;
    obs_en = imem_en;
    obs_addr = imem_addr;
    if (r) begin
      m_pc = 0; q.delete(); m_instr = 0; m_pcn = 0; m_cnt = 0;
    end else if (rd) begin
      m_pc = tgt; q.delete(); m_instr = 0; m_pcn = 0;
    end else if (!h) begin
      if (q.size() > 0) begin
        a = q.pop_front();
        m_instr = memf(a); m_pcn = a + 4; m_cnt = m_cnt + 1;
      end else begin
        m_instr = 0; m_pcn = 0;
      end
      q.push_back(m_pc);
      m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 32'h80, 1);
    checks += 2;
    if (obs_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", obs_en); end
    if (if_id_instruction !== 0 || if_id_pc_next !== 0 || fetch_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %0d want 0 0 0", if_id_instruction, if_id_pc_next, fetch_count);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      checks += 3;
      if (obs_en !== exp_en || (exp_en && obs_addr !== exp_addr)) begin
        errors++; $display("FAIL stream_req got %b %h want %b %h", obs_en, obs_addr, exp_en, exp_addr);
      end
      if (if_id_instruction !== m_instr || if_id_pc_next !== m_pcn) begin
        errors++; $display("FAIL stream_ifid got %h %h want %h %h", if_id_instruction, if_id_pc_next, m_instr, m_pcn);
      end
      if (fetch_count !== m_cnt) begin errors++; $display("FAIL stream_count got %0d want %0d", fetch_count, m_cnt); end
      if (i == 1) begin
        checks++;
        if (if_id_instruction !== 32'h20080000 || if_id_pc_next !== 32'd4) begin
          errors++; $display("FAIL stream_first got %h %h want 20080000 4", if_id_instruction, if_id_pc_next);
        end
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 6; i++) begin
      cyc(i == 2, 0, 0, 0, 0, 0);
      checks += 3;
      if (obs_en !== exp_en || (exp_en && obs_addr !== exp_addr)) begin
        errors++; $display("FAIL stall_req got %b %h want %b %h", obs_en, obs_addr, exp_en, exp_addr);
      end
      if (if_id_instruction !== m_instr || if_id_pc_next !== m_pcn) begin
        errors++; $display("FAIL stall_ifid got %h %h want %h %h", if_id_instruction, if_id_pc_next, m_instr, m_pcn);
      end
      if (fetch_count !== m_cnt) begin errors++; $display("FAIL stall_count got %0d want %0d", fetch_count, m_cnt); end
    end
  endtask

  task automatic test_breakpoint;
    logic [31:0] frozen;
    cyc(0, 0, 0, 0, 0, 0);
    frozen = if_id_pc_next;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      checks += 2;
      if (obs_en !== 1'b0) begin errors++; $display("FAIL bkpt_en got %b want 0", obs_en); end
      if (if_id_pc_next !== frozen) begin errors++; $display("FAIL bkpt_frozen got %h want %h", if_id_pc_next, frozen); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      checks += 2;
      if (obs_en !== 1'b1) begin errors++; $display("FAIL bkpt_release_en got %b want 1", obs_en); end
      if (if_id_instruction !== m_instr || if_id_pc_next !== m_pcn || fetch_count !== m_cnt) begin
        errors++; $display("FAIL bkpt_ifid got %h %h %0d want %h %h %0d",
                           if_id_instruction, if_id_pc_next, fetch_count, m_instr, m_pcn, m_cnt);
      end
    end
    checks++;
    if (if_id_pc_next !== frozen + 12) begin
      errors++; $display("FAIL bkpt_no_gap got %h want %h", if_id_pc_next, frozen + 12);
    end
  endtask

  task automatic test_redirect;
    cyc(0, 0, 0, 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_instruction !== 0 || if_id_pc_next !== 0) begin
      errors++; $display("FAIL redir_bubble got %h %h want 0 0", if_id_instruction, if_id_pc_next);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_instruction !== 32'h20080010 || if_id_pc_next !== 32'h44) begin
      errors++; $display("FAIL redir_target got %h %h want 20080010 44", if_id_instruction, if_id_pc_next);
    end
  endtask

  task automatic test_redirect_hold;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h200, 0);
    checks++;
    if (obs_en !== 1'b1) begin errors++; $display("FAIL redir_hold_en got %b want 1", obs_en); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      checks += 2;
      if (obs_addr !== exp_addr) begin errors++; $display("FAIL redir_hold_addr got %h want %h", obs_addr, exp_addr); end
      if (if_id_instruction !== m_instr || if_id_pc_next !== m_pcn || fetch_count !== m_cnt) begin
        errors++; $display("FAIL redir_hold_ifid got %h %h %0d want %h %h %0d",
                           if_id_instruction, if_id_pc_next, fetch_count, m_instr, m_pcn, m_cnt);
      end
    end
  endtask

  task automatic test_reset_hold;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    checks++;
    if (if_id_instruction !== 0 || if_id_pc_next !== 0 || fetch_count !== 0) begin
      errors++; $display("FAIL rst_hold got %h %h %0d want 0 0 0", if_id_instruction, if_id_pc_next, fetch_count);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_en !== 1'b1 || obs_addr !== 32'd0) begin
      errors++; $display("FAIL rst_hold_restart got %b %h want 1 0", obs_en, obs_addr);
    end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 0, 1, 32'hFFFFFFF8, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_pc_next !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_a got %h want fffffffc", if_id_pc_next); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_pc_next !== 32'd0 || if_id_instruction !== memf(32'hFFFFFFFC)) begin
      errors++; $display("FAIL wrap_b got %h %h want %h 0", if_id_instruction, if_id_pc_next, memf(32'hFFFFFFFC));
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_addr !== 32'd4) begin errors++; $display("FAIL wrap_pc got %h want 4", obs_addr); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
          $urandom_range(0, 49) == 0);
      checks += 3;
      if (obs_en !== exp_en || (exp_en && obs_addr !== exp_addr)) begin
        errors++; $display("FAIL rand_req got %b %h want %b %h", obs_en, obs_addr, exp_en, exp_addr);
      end
      if (if_id_instruction !== m_instr || if_id_pc_next !== m_pcn) begin
        errors++; $display("FAIL rand_ifid got %h %h want %h %h", if_id_instruction, if_id_pc_next, m_instr, m_pcn);
      end
      if (fetch_count !== m_cnt) begin errors++; $display("FAIL rand_count got %0d want %0d", fetch_count, m_cnt); end
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_breakpoint;
    test_redirect;
    test_redirect_hold;
    test_reset_hold;
    test_wrap;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
